// File: rtl/seq_shifter_if.sv
// seq_shifter_if: request/response bundle for the sequential shifter.
// The master side issues requests and consumes results; the slave side is the shifter.
interface seq_shifter_if #(
  parameter int WIDTH = 32
) ();
  localparam int SHW = $clog2(WIDTH);

  // Request channel
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand;
  logic [SHW-1:0]   shamt;
  logic             abort;

  // Response channel
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output in_valid, op, operand, shamt, abort, out_ready,
    input  in_ready, out_valid, result, err
  );

  modport slave (
    input  in_valid, op, operand, shamt, abort, out_ready,
    output in_ready, out_valid, result, err
  );
endinterface

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle barrel-less shifter (SLL/SRL/SRA/ROR), at most STEP
// bit positions per clock. One request in flight; IDLE -> SHIFT -> DONE.
// Optional feature macro: SEQ_SHIFTER_ROR_EN. When undefined, op=11 is accepted
// but rejected (result=0, err=1) and no rotate datapath exists.
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic        clk,
  input  logic        rst,
  seq_shifter_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // The remaining count never exceeds WIDTH-1, so a STEP of WIDTH behaves as
  // WIDTH-1 and the per-cycle amount always fits the SHW-bit shift field.
  localparam int             STEP_CAP = (STEP < WIDTH) ? STEP : WIDTH - 1;
  localparam logic [SHW-1:0] STEP_AMT = SHW'(STEP_CAP);

`ifdef SEQ_SHIFTER_ROR_EN
  localparam bit             ROR_EN    = 1'b1;
  localparam logic [SHW:0]   WIDTH_AMT = (SHW + 1)'(WIDTH);
`else
  localparam bit             ROR_EN    = 1'b0;
`endif

  logic [1:0]       state;
  logic [1:0]       op_q;       // operation captured at accept
  logic [WIDTH-1:0] work;       // partially shifted value
  logic [SHW-1:0]   remaining;  // bit positions still to shift
  logic [WIDTH-1:0] result_q;
  logic             err_q;

  logic [SHW-1:0]   step_amt;
  logic             last_step;
  logic [WIDTH-1:0] shifted;
  logic             reject_op;

  // A rotate request is only rejected when the rotate datapath is absent.
  assign reject_op = !ROR_EN && (bus.op == OP_ROR);

  // Per-cycle shift amount: min(STEP, remaining).
  always_comb begin
    step_amt  = (remaining > STEP_AMT) ? STEP_AMT : remaining;
    last_step = (remaining == step_amt);
  end

  // One step of the selected shift applied to the working register.
  always_comb begin
    // NOTE: default assignment first so every path drives shifted; a missed
    // branch in always_comb would otherwise infer a latch.
    shifted = '0;
    case (op_q)
      OP_SLL:  shifted = work << step_amt;
      OP_SRL:  shifted = work >> step_amt;
      // The MSB of work is the captured operand MSB and is never altered by
      // an arithmetic right shift, so successive steps keep filling with it.
      OP_SRA:  shifted = $signed(work) >>> step_amt;
`ifdef SEQ_SHIFTER_ROR_EN
      OP_ROR:  shifted = (work >> step_amt) | (work << (WIDTH_AMT - {1'b0, step_amt}));
`endif
      default: shifted = '0;
    endcase
  end

  // Control FSM plus datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments throughout so every register sees the
    // pre-edge value of every other register, independent of statement order.
    if (!rst) begin
      state     <= IDLE;
      op_q      <= OP_SLL;
      work      <= '0;
      remaining <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // abort is deliberately ignored here: there is nothing to cancel.
          if (bus.in_valid) begin
            op_q      <= bus.op;
            work      <= bus.operand;
            remaining <= bus.shamt;
            if (reject_op) begin
              remaining <= '0;
              result_q  <= '0;
              err_q     <= 1'b1;
              state     <= DONE;
            end else if (bus.shamt == '0) begin
              result_q  <= bus.operand;
              err_q     <= 1'b0;
              state     <= DONE;
            end else begin
              state     <= SHIFT;
            end
          end
        end

        SHIFT: begin
          // abort wins over completion; result keeps its previous value.
          if (bus.abort) begin
            state <= IDLE;
          end else begin
            work      <= shifted;
            remaining <= remaining - step_amt;
            if (last_step) begin
              result_q <= shifted;
              err_q    <= 1'b0;
              state    <= DONE;
            end
          end
        end

        DONE: begin
          // Either an abort or a consumer handshake releases the result;
          // no new request is taken on this edge since in_ready is low.
          if (bus.abort || bus.out_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs are pure decodes of the state register.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  // err_q keeps its last value after DONE; gate it so err only shows with out_valid.
  assign bus.err       = (state == DONE) && err_q;

  // A presented result must not move while the consumer stalls.
  a_done_hold: assert property (@(posedge clk) disable iff (!rst)
    (state == DONE && !bus.out_ready && !bus.abort)
      |=> (state == DONE && $stable(result_q) && $stable(err_q)));

  // SHIFT is only ever entered or kept with work still left to do.
  a_shift_nonzero: assert property (@(posedge clk) disable iff (!rst)
    (state == SHIFT) |-> (remaining != '0));

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width; legal values are powers of two, 8 or more.
REQ-002 SHALL have parameter STEP, default 1, meaning maximum bit positions shifted per cycle; legal values are powers of two, 1 to WIDTH.
REQ-003 SHALL derive SHW = log2(WIDTH) as the shift-amount width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-009 operand  input  WIDTH  value to shift.
REQ-010 shamt  input  SHW  shift amount, unsigned.
REQ-011 abort  input  1  synchronous cancel of the in-flight operation.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer takes the result.
REQ-014 result  output  WIDTH  shifted value.
REQ-015 err  output  1  result belongs to a rejected (illegal) op; valid with out_valid.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE.
REQ-017 Handshake: a request is accepted on a rising edge with in_valid=1 and in_ready=1; op, operand and shamt are captured then and later input changes are ignored.
REQ-018 IDLE -> SHIFT on accept with shamt != 0; IDLE -> DONE on accept with shamt = 0, giving result = operand.
REQ-019 In SHIFT, each cycle SHALL shift the working register by min(STEP, remaining) and decrement remaining by the same amount; SHIFT -> DONE on the cycle remaining reaches 0.
REQ-020 Latency from accept edge to out_valid=1 SHALL be exactly max(1, ceil(shamt/STEP)) cycles.
REQ-021 SLL fills with zeros, SRL fills with zeros, SRA fills with the captured operand MSB, ROR rotates right; all arithmetic is modulo WIDTH bits.
REQ-022 In DONE, out_valid=1 and result/err SHALL remain stable until out_ready=1; DONE -> IDLE on that edge; no new accept on the same edge.
REQ-023 out_valid=0 and err=0 in IDLE and SHIFT; result holds its last value outside DONE.
REQ-024 abort=1 in SHIFT or DONE SHALL force IDLE on the next edge with no result delivered; abort in IDLE has no effect; abort has priority over out_ready and over SHIFT completion.
REQ-025 in_valid with shamt = WIDTH-1 (maximum) SHALL be handled like any other amount; no value of shamt is illegal.

Reset
REQ-026 While rst=0: state = IDLE, in_ready=1, out_valid=0, err=0, result=0, working and remaining registers = 0, independent of clk.
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL discard the operation; first accept is possible on the first rising edge after rst returns to 1.

Configuration
REQ-028 Macro SEQ_SHIFTER_ROR_EN: when defined, op=11 performs ROR per REQ-019 to REQ-021 with err=0.
REQ-029 When SEQ_SHIFTER_ROR_EN is not defined, op=11 SHALL be accepted, go directly to DONE one cycle later, and present result=0 with err=1; no rotate logic is synthesised.

Verification
REQ-030 WIDTH=32, STEP=1: SLL 0x0F000000 by 4 -> out_valid 4 cycles after accept, result 0xF0000000, err=0; then SLL 0xF0000000 by 4 -> result 0x00000000.
REQ-031 WIDTH=32, STEP=4: SRA 0x80000000 by 31 -> out_valid after 8 cycles, result 0xFFFFFFFF; SRL same operand and amount -> 0x00000001.
REQ-032 shamt=0, SLL 0x12345678 -> out_valid after 1 cycle, result 0x12345678; hold out_ready=0 for 5 cycles -> result and out_valid stable, in_ready=0 throughout.
REQ-033 ROR 0x00000001 by 1 -> with SEQ_SHIFTER_ROR_EN result 0x80000000, err=0; without it result 0x00000000, err=1 after 1 cycle.
REQ-034 STEP=1, SLL by 20, abort asserted 3 cycles after accept -> IDLE next edge, out_valid never asserted, in_ready=1; rst pulsed low mid-SHIFT -> all outputs at reset values immediately.
